// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU op codes and execute-stage state encoding, also imported by the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_OP_AND = 4'b0000;
  localparam logic [3:0] ALU_OP_OR  = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD = 4'b0010;
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;
  localparam logic [3:0] ALU_OP_MUL = 4'b0011;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

endpackage

// File: rtl/alu_exec_stage_mul.sv
// alu_mul_iter: shift-add multiplier, one partial product per cycle, done after WIDTH steps.
// Holds o_done/o_prod until i_ack so the caller can wait for a free output register.
module alu_mul_iter #(
  parameter int WIDTH     = 32,
  parameter int MUL_CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod
);

  localparam logic [MUL_CNT_W-1:0] STEPS = MUL_CNT_W'(WIDTH);

  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_acc;
  logic [MUL_CNT_W-1:0] r_cnt;
  logic                 r_run;
  logic                 w_stepping;

  assign w_stepping = r_run && (r_cnt != STEPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (w_stepping) begin
      // Only the low WIDTH bits of the product are kept, so the shifted-out bits never matter.
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end else if (i_ack) begin
      r_run <= 1'b0;
    end
  end

  assign o_done = r_run && (r_cnt == STEPS);
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU (AND/OR/ADD/SUB): 1-cycle registered result, or WIDTH+1 cycles for MUL when ALU_EXEC_MUL_EN is defined.
// Holds result while out_ready=0; in_ready drops while output is blocked or a MUL is busy.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MUL_CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("alu_exec_stage: WIDTH must be 8..64");
  end
  if ((2 ** MUL_CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("alu_exec_stage: MUL_CNT_W too narrow for WIDTH");
  end

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ill;
  logic             r_out_vld;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ill;
  logic             w_free;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_load_res;
  logic             w_load_ill;

  assign w_free = !r_out_vld || out_ready;

  always_comb begin
    w_alu_res = '0;
    w_alu_ill = 1'b0;
    case (operation)
      ALU_OP_AND: w_alu_res = op_a & op_b;
      ALU_OP_OR:  w_alu_res = op_a | op_b;
      ALU_OP_ADD: w_alu_res = op_a + op_b;
      ALU_OP_SUB: w_alu_res = op_a - op_b;
`ifndef ALU_EXEC_MUL_EN
      ALU_OP_MUL: w_alu_ill = 1'b1;
`endif
      default:    w_alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_done;
  logic             w_mul_ack;
  logic [WIDTH-1:0] w_mul_prod;

  assign w_is_mul    = (operation == ALU_OP_MUL);
  assign in_ready    = (r_state == ST_IDLE) && w_free;
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && w_is_mul;
  // A finished product waits here until the output register can take it.
  assign w_mul_ack   = (r_state == ST_BUSY) && w_mul_done && w_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_mul_ack)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  alu_mul_iter #(
    .WIDTH     (WIDTH),
    .MUL_CNT_W (MUL_CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_ack   (w_mul_ack),
    .i_a     (op_a),
    .i_b     (op_b),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );

  always_comb begin
    w_load     = 1'b0;
    w_load_res = w_alu_res;
    w_load_ill = w_alu_ill;
    if (w_accept && !w_is_mul) begin
      w_load = 1'b1;
    end else if (w_mul_ack) begin
      w_load     = 1'b1;
      w_load_res = w_mul_prod;
      w_load_ill = 1'b0;
    end
  end
`else
  assign in_ready   = w_free;
  assign w_accept   = in_valid && in_ready;
  assign w_load     = w_accept;
  assign w_load_res = w_alu_res;
  assign w_load_ill = w_alu_ill;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ill     <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (w_load) begin
      r_result  <= w_load_res;
      r_zero    <= (w_load_res == '0);
      r_ill     <= w_load_ill;
      r_out_vld <= 1'b1;
    end else if (out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_valid  = r_out_vld;
  assign result     = r_result;
  assign zero       = r_zero;
  assign illegal_op = r_ill;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execute-stage ALU that consumes the 4-bit Operation code from the ALU control decoder, along with two operands. It produces a registered result and zero flag over a valid/ready handshake. Single-cycle ops complete with 1-cycle latency at full throughput. An optional iterative multiplier adds a multi-cycle path. The stage sits between the register-read/ALU-control stage and the memory/writeback stage.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range is 8 to 64.
- MUL_CNT_W, 6, width of the iteration counter; must satisfy 2^MUL_CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation/operands valid
- in_ready  output  1  stage can accept this cycle
- operation  input  4  ALU op code from ALU control
- op_a  input  WIDTH  operand A (rs1)
- op_b  input  WIDTH  operand B (rs2 or immediate)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered (result == 0)
- illegal_op  output  1  registered; the op code was not recognised

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, zero=0, illegal_op=0, counter=0, multiplier registers=0. Release is synchronised by the team reset synchroniser upstream, not inside this block.
- Op codes (unsigned compare):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no carry or overflow outputs.
- States: IDLE, BUSY (present only with the optional feature).
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational; there is no path from in_valid to in_ready.
- Accept: the transfer occurs when in_valid && in_ready at the clock edge.
  - Single-cycle op: result, zero and illegal_op load on that edge; out_valid=1 the next cycle (latency 1).
- Output hold: while out_valid && !out_ready, result/zero/illegal_op stay stable and no new transfer is accepted.
- Simultaneous out_ready and accept: the old result retires and the new result loads on the same edge. out_valid stays 1, giving back-to-back throughput of 1 op/cycle.
- Retire with no accept: out_valid clears to 0; result keeps its last value.
- Unrecognised op code: the transfer is still accepted. result=0, zero=1, illegal_op=1 for that result only.
- Input values while !in_valid are ignored, including X values.
- Reset mid-operation (BUSY or holding output): everything returns to reset values immediately. The in-flight op is dropped.

Optional Feature:
- Macro: ALU_EXEC_MUL_EN.
- Defined:
  - Op 0011 = MUL, lower WIDTH bits of the unsigned product (identical to the signed low half).
  - On accept, enter BUSY with counter=0. Each cycle performs one shift-add step on a latched copy of the operands.
  - After WIDTH steps, return to IDLE, load result/zero, and set out_valid the following cycle. Latency is WIDTH+1 cycles from accept to out_valid.
  - in_ready=0 throughout BUSY.
  - MUL is accepted only when out_valid==0 or out_ready==1 (normal in_ready rule). A prior result still waiting in the output register remains held and valid during BUSY.
  - The MUL result loads only when the output register is free. If it is not free, BUSY extends until out_ready retires the older result.
- Not defined: 0011 is treated as an unrecognised op. The BUSY state and multiplier logic are absent.

Decomposition:
- Package alu_pkg holds:
  - op-code localparams ALU_OP_AND=4'b0000, ALU_OP_OR=4'b0001, ALU_OP_ADD=4'b0010, ALU_OP_SUB=4'b0110, ALU_OP_MUL=4'b0011;
  - the state enum {ST_IDLE, ST_BUSY}.
- The ALU control decoder imports the same constants.
- One sub-module, alu_mul_iter: shift-add multiplier with start/done, clk/rst_n, and WIDTH/MUL_CNT_W parameters. It is instantiated only under ALU_EXEC_MUL_EN.

Test Plan:
- Reset, then check outputs; then ADD 0x0000_0005 + 0x0000_0003 with out_ready=1 -> out_valid=0, result=0, zero=0, illegal_op=0 after reset; next cycle result=0x0000_0008, zero=0, out_valid=1 for exactly 1 cycle.
- SUB 0x0000_0007 - 0x0000_0007 -> result=0, zero=1. SUB 0 - 1 -> result=0xFFFF_FFFF, zero=0 (wrap).
- Back-to-back AND 0xF0F0_F0F0 & 0xFF00_FF00, then OR 0x0F0F_0000 | 0x0000_00F0, out_ready=1 -> results 0xF000_F000 and 0x0F0F_00F0 on consecutive cycles; in_ready held 1.
- Backpressure: out_ready=0 for 3 cycles with a second op pending -> in_ready=0 and result stable for those 3 cycles; out_ready=1 -> first result retires and the second loads on the same edge.
- Op 4'b1111 with a=5, b=3 -> result=0, zero=1, illegal_op=1; the next legal ADD clears illegal_op. With ALU_EXEC_MUL_EN undefined, op 0011 behaves identically.
- With ALU_EXEC_MUL_EN: MUL 0x0001_0003 * 0x0000_0005 -> out_valid exactly 33 cycles after accept, result=0x0005_000F, in_ready=0 throughout BUSY. Asserting rst_n=0 at cycle 10 of BUSY -> out_valid=0 and state IDLE, with no stale result after release.
